// File: rtl/bnn_pkg.sv
// ---------------------------------------------------------------------------
// bnn_pkg -- shared constants and types for the BNN classifier back end.
//
// Contents:
//   NUM_CLASSES      number of class scores per image (fixed at 10 to match
//                    the downstream one-hot decoder)
//   SCORE_W_DEFAULT  default width of a two's-complement class score
//   IDX_W            width of a class index (0..NUM_CLASSES-1)
//   argmax_state_t   ACC (collecting scores) / HOLD (result pending)
//   idx_onehot()     class index -> one-hot class vector
// ---------------------------------------------------------------------------
package bnn_pkg;

   localparam int NUM_CLASSES     = 10;
   localparam int SCORE_W_DEFAULT = 16;
   localparam int IDX_W           = 4;

   typedef enum logic {
      ACC  = 1'b0,
      HOLD = 1'b1
   } argmax_state_t;

   function automatic logic [NUM_CLASSES-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
      idx_onehot = NUM_CLASSES'(1) << idx;
   endfunction

endpackage

// File: rtl/argmax_cmp.sv
// ---------------------------------------------------------------------------
// argmax_cmp -- one step of the running argmax.
//
// Decides whether the incoming score replaces the running maximum. The first
// score of an image always wins; after that a score wins only when strictly
// greater (signed), so ties keep the lowest class index. Pure compare and
// select, so score extremes cannot overflow.
//
// Ports:
//   first     in   1        current score is class 0 of a new image
//   score     in   SCORE_W  incoming signed score
//   cur_idx   in   IDX_W    class index of the incoming score
//   run_max   in   SCORE_W  running maximum so far
//   run_idx   in   IDX_W    class index of the running maximum
//   max_out   out  SCORE_W  updated maximum
//   win_out   out  IDX_W    updated winner index
// ---------------------------------------------------------------------------
module argmax_cmp
   import bnn_pkg::*;
#(
   parameter int SCORE_W = SCORE_W_DEFAULT
) (
   input  logic                      first,
   input  logic signed [SCORE_W-1:0] score,
   input  logic        [IDX_W-1:0]   cur_idx,
   input  logic signed [SCORE_W-1:0] run_max,
   input  logic        [IDX_W-1:0]   run_idx,
   output logic signed [SCORE_W-1:0] max_out,
   output logic        [IDX_W-1:0]   win_out
);

   logic take;

   // Both operands are declared signed, so '>' is a two's-complement compare.
   assign take    = first || (score > run_max);
   assign max_out = take ? score   : run_max;
   assign win_out = take ? cur_idx : run_idx;

endmodule

// File: rtl/argmax_onehot.sv
// ---------------------------------------------------------------------------
// argmax_onehot -- streaming argmax over NUM_CLASSES signed class scores.
//
// Scores arrive one per accepted beat in class order 0..9. After the 10th
// accept the winning class is registered as a one-hot vector and held, with
// out_valid high, until the consumer takes it. in_ready is low while a result
// is pending, including the cycle the result is handed off.
//
// Optional feature (macro ARGMAX_SCORE_OUT_EN): adds output max_score, the
// winning score, registered and held alongside classes.
//
// Ports:
//   clk        in   1            rising-edge clock
//   rst        in   1            asynchronous active-high reset
//   clear      in   1            synchronous abort of the image in progress
//   in_valid   in   1            score present on in_score
//   in_ready   out  1            score accepted this cycle (state ACC)
//   in_score   in   SCORE_W      signed class score
//   out_valid  out  1            classes holds a result (state HOLD)
//   out_ready  in   1            consumer accepts the result
//   classes    out  NUM_CLASSES  one-hot winner, zero when out_valid=0
//   max_score  out  SCORE_W      winning score (ARGMAX_SCORE_OUT_EN only)
// ---------------------------------------------------------------------------
module argmax_onehot
   import bnn_pkg::*;
#(
   parameter int SCORE_W     = SCORE_W_DEFAULT,
   parameter int NUM_CLASSES = bnn_pkg::NUM_CLASSES
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clear,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [SCORE_W-1:0] in_score,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [NUM_CLASSES-1:0]    classes
`ifdef ARGMAX_SCORE_OUT_EN
   ,
   output logic signed [SCORE_W-1:0] max_score
`endif
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

   argmax_state_t             state_q, state_d;
   logic [IDX_W-1:0]          idx_q;
   logic signed [SCORE_W-1:0] run_max_q;
   logic [IDX_W-1:0]          run_win_q;
   logic [NUM_CLASSES-1:0]    classes_q;

   logic                      accept;
   logic                      last;
   logic signed [SCORE_W-1:0] cmp_max;
   logic [IDX_W-1:0]          cmp_win;

   // clear in ACC drops a score offered in the same cycle.
   assign accept = in_valid && in_ready && !clear;
   assign last   = (idx_q == LAST_IDX);

   argmax_cmp #(
      .SCORE_W (SCORE_W)
   ) u_cmp (
      .first   (idx_q == '0),
      .score   (in_score),
      .cur_idx (idx_q),
      .run_max (run_max_q),
      .run_idx (run_win_q),
      .max_out (cmp_max),
      .win_out (cmp_win)
   );

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ACC;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next state and handshake outputs
   // ---------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         ACC: begin
            in_ready = 1'b1;
            if (accept && last) state_d = HOLD;
         end
         HOLD: begin
            out_valid = 1'b1;
            // clear is ignored here: a pending result is never discarded.
            if (out_ready) state_d = ACC;
         end
         default: state_d = ACC;
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath: index counter, running max/winner, result registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (rst) begin
         idx_q     <= '0;
         run_max_q <= '0;
         run_win_q <= '0;
         classes_q <= '0;
      end else begin
         unique case (state_q)
            ACC: begin
               if (clear) begin
                  idx_q <= '0;
               end else if (accept) begin
                  run_max_q <= cmp_max;
                  run_win_q <= cmp_win;
                  if (last) begin
                     idx_q     <= '0;
                     classes_q <= idx_onehot(cmp_win);
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            HOLD: begin
               // Zeroing on hand-off keeps classes all-zero outside HOLD.
               if (out_ready) classes_q <= '0;
            end
            default: ;
         endcase
      end
   end

   assign classes = classes_q;

`ifdef ARGMAX_SCORE_OUT_EN
   logic signed [SCORE_W-1:0] max_score_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         max_score_q <= '0;
      end else if (state_q == ACC) begin
         if (accept && last) max_score_q <= cmp_max;
      end else if (out_ready) begin
         max_score_q <= '0;
      end
   end

   assign max_score = max_score_q;
`endif

endmodule

// File: tb/tb_argmax_onehot.sv
// ---------------------------------------------------------------------------
// tb_argmax_onehot -- directed self-checking bench for argmax_onehot.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// Define ARGMAX_SCORE_OUT_EN to also exercise the max_score output.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_argmax_onehot;

   localparam int SW = 16;
   localparam int NC = 10;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 clear;
   logic                 in_valid;
   logic                 in_ready;
   logic signed [SW-1:0] in_score;
   logic                 out_valid;
   logic                 out_ready;
   logic [NC-1:0]        classes;
`ifdef ARGMAX_SCORE_OUT_EN
   logic signed [SW-1:0] max_score;
`endif

   int checks   = 0;
   int failures = 0;

   typedef logic signed [SW-1:0] img_t [NC];

   always #5 clk = ~clk;

   argmax_onehot #(
      .SCORE_W     (SW),
      .NUM_CLASSES (NC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_score  (in_score),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .classes   (classes)
`ifdef ARGMAX_SCORE_OUT_EN
      ,
      .max_score (max_score)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one score and hold it for exactly one accepted beat.
   task automatic push(input logic signed [SW-1:0] s);
      int n = 0;
      in_valid = 1'b1;
      in_score = s;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL push_timeout in_ready=%b required=1", in_ready);
      end
      tick();
      in_valid = 1'b0;
   endtask

   // Push scores 0..8 and check no result appears early, then push score 9.
   task automatic send_image(input img_t img, input string tag);
      for (int i = 0; i < NC - 1; i++) push(img[i]);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL %s_early_valid out_valid=%b required=0", tag, out_valid);
      end
      push(img[NC-1]);
   endtask

   task automatic test_reset();
      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_score = '0; out_ready = 1'b0;
      #12;
      checks++;
      if (out_valid !== 1'b0 || classes !== '0) begin
         failures++;
         $display("FAIL reset_outputs out_valid=%b classes=%b required 0/0", out_valid, classes);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready in_ready=%b required=1", in_ready);
      end
   endtask

   task automatic test_ascending();
      img_t img;
      for (int i = 0; i < NC; i++) img[i] = SW'(i);
      out_ready = 1'b1;
      send_image(img, "asc");
      checks++;
      if (out_valid !== 1'b1 || classes !== 10'b1000000000) begin
         failures++;
         $display("FAIL asc_result out_valid=%b classes=%b required 1/1000000000", out_valid, classes);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || classes !== '0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL asc_one_cycle out_valid=%b classes=%b in_ready=%b required 0/0/1",
                  out_valid, classes, in_ready);
      end
   endtask

   task automatic test_tie();
      img_t img;
      for (int i = 0; i < NC; i++) img[i] = -16'sd5;
      out_ready = 1'b1;
      send_image(img, "tie");
      checks++;
      if (out_valid !== 1'b1 || classes !== 10'b0000000001) begin
         failures++;
         $display("FAIL tie_result out_valid=%b classes=%b required 1/0000000001", out_valid, classes);
      end
      tick();
   endtask

   task automatic test_extremes_hold();
      img_t img;
      for (int i = 0; i < NC; i++) img[i] = 16'sh8000;
      img[3] = 16'sh7FFF;
      out_ready = 1'b0;
      send_image(img, "ext");
      // Keep offering a score during HOLD; it must not be taken.
      in_valid = 1'b1;
      in_score = 16'sh7FFF;
      for (int c = 0; c < 5; c++) begin
         clear = (c == 2);   // clear in HOLD must not discard the result
         checks++;
         if (out_valid !== 1'b1 || classes !== 10'b0000001000 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL ext_hold_c%0d out_valid=%b classes=%b in_ready=%b required 1/0000001000/0",
                     c, out_valid, classes, in_ready);
         end
         tick();
      end
      clear = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || classes !== 10'b0000001000) begin
         failures++;
         $display("FAIL ext_after_clear out_valid=%b classes=%b required 1/0000001000", out_valid, classes);
      end
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || classes !== '0) begin
         failures++;
         $display("FAIL ext_reenter_acc out_valid=%b in_ready=%b classes=%b required 0/1/0",
                  out_valid, in_ready, classes);
      end
   endtask

   task automatic test_clear_abort();
      img_t img;
      img = '{16'sd10, 16'sd20, 16'sd30, 16'sd40, 16'sd50, 16'sd60, 16'sd70,
              16'sd5, 16'sd5, 16'sd5};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) push(16'sd1000);
      // Score offered together with clear is dropped.
      clear    = 1'b1;
      in_valid = 1'b1;
      in_score = 16'sd2000;
      tick();
      clear    = 1'b0;
      in_valid = 1'b0;
      send_image(img, "clr");
      checks++;
      if (out_valid !== 1'b1 || classes !== 10'b0001000000) begin
         failures++;
         $display("FAIL clr_result out_valid=%b classes=%b required 1/0001000000", out_valid, classes);
      end
      tick();
   endtask

   task automatic test_reset_in_hold();
      img_t img;
      for (int i = 0; i < NC; i++) img[i] = SW'(NC - i);
      out_ready = 1'b0;
      send_image(img, "rsth");
      checks++;
      if (out_valid !== 1'b1 || classes !== 10'b0000000001) begin
         failures++;
         $display("FAIL rsth_pending out_valid=%b classes=%b required 1/0000000001", out_valid, classes);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || classes !== '0) begin
         failures++;
         $display("FAIL rsth_async out_valid=%b classes=%b required 0/0", out_valid, classes);
      end
      tick();
      rst = 1'b0;
      tick();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL rsth_release in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
      end
   endtask

   // Mid-image reset must discard the partial image and restart at index 0.
   task automatic test_reset_mid_image();
      img_t img;
      for (int i = 0; i < NC; i++) img[i] = -16'sd100;
      img[8] = -16'sd1;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) push(16'sd500);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      send_image(img, "rstm");
      checks++;
      if (out_valid !== 1'b1 || classes !== 10'b0100000000) begin
         failures++;
         $display("FAIL rstm_result out_valid=%b classes=%b required 1/0100000000", out_valid, classes);
      end
      tick();
   endtask

`ifdef ARGMAX_SCORE_OUT_EN
   task automatic test_score_out();
      img_t img;
      img = '{16'sd3, -16'sd2, 16'sd7, 16'sd7, 16'sd1, 16'sd0, 16'sd0, 16'sd0,
              16'sd0, 16'sd0};
      out_ready = 1'b1;
      send_image(img, "sco");
      checks++;
      if (classes !== 10'b0000000100 || max_score !== 16'sd7) begin
         failures++;
         $display("FAIL sco_result classes=%b max_score=%0d required 0000000100/7", classes, max_score);
      end
      tick();
      checks++;
      if (max_score !== 16'sd0) begin
         failures++;
         $display("FAIL sco_cleared max_score=%0d required=0", max_score);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_ascending();
      test_tie();
      test_extremes_hold();
      test_clear_abort();
      test_reset_in_hold();
      test_reset_mid_image();
`ifdef ARGMAX_SCORE_OUT_EN
      test_score_out();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/argmax_onehot.md
ARGMAX_ONEHOT -- requirements
Module: argmax_onehot

Interface
REQ-001 SHALL have parameter SCORE_W, default 16, meaning the width of each two's-complement class score.
REQ-002 SHALL have parameter NUM_CLASSES, default 10, meaning the number of scores per image; it is fixed at 10 to match the downstream one-hot decoder.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port clear, input, 1 bit: synchronous abort of the image in progress.
REQ-006 SHALL have port in_valid, input, 1 bit: a score is present on in_score.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts a score this cycle.
REQ-008 SHALL have port in_score, input, SCORE_W bits: signed class score, presented in class order 0..9.
REQ-009 SHALL have port out_valid, output, 1 bit: classes holds a result.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port classes, output, 10 bits: one-hot winner, where bit k set means class k.

Function
REQ-012 SHALL implement two states: ACC (collecting scores) and HOLD (result pending).
REQ-013 SHALL drive in_ready=1 only in ACC, and SHALL drive out_valid=1 only in HOLD.
REQ-014 SHALL accept a score only when in_valid && in_ready, and SHALL increment a 4-bit index counter 0..9 on each accept.
REQ-015 SHALL load the running max with the score on the accept at index 0, and SHALL set the running winner index to 0.
REQ-016 SHALL, on the accepts at indices 1..9, replace the running max and winner only when the score is strictly greater (signed compare); ties keep the lowest index.
REQ-017 SHALL, on the accept at index 9, include that score in the compare, register the one-hot winner into classes, reset the index to 0, and enter HOLD on the next edge (result latency 1 cycle after the 10th accept).
REQ-018 SHALL hold classes and out_valid stable in HOLD until out_valid && out_ready, then return to ACC on the next edge.
REQ-019 SHALL NOT accept input in the cycle HOLD is exited, since in_ready is derived from the registered state.
REQ-020 SHALL make classes exactly one-hot whenever out_valid=1, and SHALL drive classes to all zeros when out_valid=0.
REQ-021 SHALL, when clear=1 in ACC, discard the partial image and reset the index to 0; a score offered in the same cycle is dropped.
REQ-022 SHALL, when clear=1 in HOLD, have no effect; a pending result is never discarded.
REQ-023 SHALL handle SCORE_W-bit extremes (most negative, most positive) without overflow, since the block only compares and never adds.

Reset
REQ-024 SHALL, on rst=1, immediately set state=ACC, index=0, running max=0, winner=0, classes=0 and out_valid=0; in_ready=1 is permitted after rst deasserts.
REQ-025 SHALL, on reset mid-image or during HOLD, discard all partial or pending results.

Configuration
REQ-026 SHALL, when ARGMAX_SCORE_OUT_EN is defined, add output port max_score (SCORE_W bits, signed) carrying the winning score, registered alongside classes with the same valid/hold/reset rules (reset 0).
REQ-027 SHALL, when ARGMAX_SCORE_OUT_EN is undefined, omit the max_score port and its register; all other behaviour SHALL be identical.

Structure
REQ-028 SHALL place NUM_CLASSES (10), the default SCORE_W (16) and the ACC/HOLD state encoding in the shared package bnn_pkg.
REQ-029 SHALL isolate the signed strictly-greater compare and the winner-index mux in one sub-module, argmax_cmp.

Verification
REQ-030 SHALL verify: scores 0,1,...,9 with out_ready=1 -> classes=10'b1000000000 one cycle after the 10th accept, with out_valid high for 1 cycle.
REQ-031 SHALL verify: scores all -5 (a tie) -> classes=10'b0000000001.
REQ-032 SHALL verify: score 0x7FFF at index 3, 0x8000 elsewhere, with out_ready=0 for 5 cycles -> classes=10'b0000001000 held stable, in_ready=0 throughout, and ACC re-entered after out_ready=1.
REQ-033 SHALL verify: clear pulsed after 4 accepts, then a full image with its max at index 6 -> classes=10'b0001000000, with no influence from the aborted scores.
REQ-034 SHALL verify: rst asserted during HOLD -> out_valid=0 and classes=0 immediately (before the next clock edge), with in_ready=1 after release.
REQ-035 SHALL verify: with ARGMAX_SCORE_OUT_EN defined, scores 3,-2,7,7,1,0,0,0,0,0 -> classes=10'b0000000100 and max_score=7.
